// File: rtl/sha256_bus_pkg.sv
// Shared definitions for the SHA-256 register-mapped bus:
// slave address map, transfer sizes and the master state encoding.
package sha256_bus_pkg;

    localparam logic [4:0] ADDR_MSG_BASE  = 5'd0;
    localparam logic [4:0] ADDR_HASH_BASE = 5'd16;
    localparam int         NUM_MSG_WORDS  = 16;
    localparam int         NUM_HASH_WORDS = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        START,
        WAIT,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/sha256_bus_master.sv
// SHA-256 bus initiator: writes a 512-bit block to the slave, starts
// the core, waits a fixed time, then reads the 256-bit digest back.
module sha256_bus_master
    import sha256_bus_pkg::*;
#(
    parameter  int WAIT_CYCLES = 70,
    localparam int CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic         iStart,
    input  logic [511:0] iBlock,
    input  logic [31:0]  iReadData,
    output logic         oChipSelect_n,
    output logic         oWrite_n,
    output logic         oRead_n,
    output logic [4:0]   oAddress,
    output logic [31:0]  oData,
    output logic         oCoreStart,
    output logic [255:0] oDigest,
    output logic         oBusy,
    output logic         oDone
);

    state_t             state_q, state_d;
    logic [3:0]         wr_q, wr_d;
    logic [3:0]         rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [511:0]       blk_q, blk_d;
    logic [255:0]       dig_q, dig_d;
    logic [2:0]         hidx;

    // State register
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iStart) state_d = WRITE;
            WRITE:   if (wr_q == 4'(NUM_MSG_WORDS - 1)) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = READ;
            READ:    if (rd_q == 4'(NUM_HASH_WORDS)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, latched block and digest capture
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        blk_d = blk_q;
        dig_d = dig_q;
        hidx  = 3'(rd_q - 4'd1);
        unique case (state_q)
            IDLE: begin
                wr_d = '0;
                rd_d = '0;
                if (iStart) blk_d = iBlock;
            end
            WRITE: wr_d = wr_q + 4'd1;
            START: cnt_d = CNT_W'(WAIT_CYCLES - 1);
            WAIT:  if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            READ: begin
                rd_d = rd_q + 4'd1;
                // Data for issue j arrives one cycle later, at rd_q = j+1
                if (rd_q != 4'd0) dig_d[{hidx, 5'd0} +: 32] = iReadData;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge iClk) begin
        if (iReset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            blk_q <= '0;
            dig_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            blk_q <= blk_d;
            dig_q <= dig_d;
        end
    end

    // Bus strobes and status decoded from the current state
    always_comb begin
        oChipSelect_n = 1'b1;
        oWrite_n      = 1'b1;
        oRead_n       = 1'b1;
        oAddress      = '0;
        oData         = '0;
        oCoreStart    = 1'b0;
        oDone         = 1'b0;
        oBusy         = (state_q != IDLE);
        unique case (state_q)
            WRITE: begin
                oChipSelect_n = 1'b0;
                oWrite_n      = 1'b0;
                oAddress      = ADDR_MSG_BASE + {1'b0, wr_q};
                oData         = blk_q[{wr_q, 5'd0} +: 32];
            end
            START: oCoreStart = 1'b1;
            READ: begin
                // Last READ cycle only drains the final capture
                if (rd_q < 4'(NUM_HASH_WORDS)) begin
                    oChipSelect_n = 1'b0;
                    oRead_n       = 1'b0;
                    oAddress      = ADDR_HASH_BASE + {1'b0, rd_q};
                end
            end
            DONE:    oDone = 1'b1;
            default: ;
        endcase
    end

    assign oDigest = dig_q;

endmodule
